// File: rtl/hazard_scoreboard_pkg.sv
// Shared core constants and types for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int unsigned LAT_W = 3;
    localparam int unsigned NREG  = 32;
    localparam int unsigned IDX_W = $clog2(NREG);
    localparam int unsigned CNT_W = $clog2(NREG) + 1;

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [LAT_W-1:0] lat_t;

    // Bubbles a consumer must wait after each producer class issues.
    localparam lat_t LAT_ALU  = lat_t'(0);
    localparam lat_t LAT_LOAD = lat_t'(1);
    localparam lat_t LAT_MULT = lat_t'(4);
    localparam lat_t LAT_AES  = lat_t'(5);

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// sb_counter: one register's pending-latency down-counter.
//   clear     - force to zero (pipeline flush)
//   hold      - freeze (back end stalled)
//   load      - new producer issued: take max(load_val, decremented value)
//   cnt       - current (registered) count
//   cnt_nxt_c - next-state value, used by the parent's registered popcount
module sb_counter
    import hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             hold,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt,
    output logic [LAT_W-1:0] cnt_nxt_c
);

    lat_t cnt_q;
    lat_t cnt_d;
    lat_t dec;

    // Saturating decrement; a load never shortens an older, longer producer.
    always_comb begin
        dec   = (cnt_q != '0) ? cnt_q - lat_t'(1) : '0;
        cnt_d = dec;
        if (clear) begin
            cnt_d = '0;
        end else if (hold) begin
            cnt_d = cnt_q;
        end else if (load && (load_val > dec)) begin
            cnt_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign cnt_nxt_c = cnt_d;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks per-register producer latency and stalls ID until
// every source operand of the instruction in ID is forwardable.
//   in_ID_*        - sources of the instruction currently in ID
//   in_issue_*     - destination/latency of the instruction advancing to EX
//   in_hold        - back end frozen, counters do not advance
//   in_flush       - clear all pending producers
//   out_stall      - combinational: ID must not advance
//   out_issue_fire - combinational: issue accepted this cycle
//   out_busy_cnt   - registered count of registers with pending results
//   out_busy       - out_busy_cnt != 0
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       in_ID_rs_idx,
    input  logic [4:0]       in_ID_rt_idx,
    input  logic             in_ID_use_rs,
    input  logic             in_ID_use_rt,
    input  logic             in_issue_valid,
    input  logic             in_issue_RegWr,
    input  logic [4:0]       in_issue_rd_idx,
    input  logic [LAT_W-1:0] in_issue_lat,
    input  logic             in_hold,
    input  logic             in_flush,
    output logic             out_stall,
    output logic             out_issue_fire,
    output logic [5:0]       out_busy_cnt,
    output logic             out_busy
);

    lat_t             cnt     [NREG];
    lat_t             cnt_nxt [NREG];
    logic             hazard_rs;
    logic             hazard_rt;
    logic             issue_rec;
    logic [CNT_W-1:0] busy_cnt_q;
    logic [CNT_W-1:0] busy_cnt_d;

    // Register 0 is hard-wired clean; the rest each own a counter.
    for (genvar r = 0; r < int'(NREG); r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign cnt[r]     = '0;
            assign cnt_nxt[r] = '0;
        end else begin : g_cnt
            sb_counter u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .clear     (in_flush),
                .hold      (in_hold),
                .load      (issue_rec && (reg_idx_t'(in_issue_rd_idx) == reg_idx_t'(r))),
                .load_val  (in_issue_lat),
                .cnt       (cnt[r]),
                .cnt_nxt_c (cnt_nxt[r])
            );
        end
    end

    // Stall depends only on current state, never on this cycle's issue.
    always_comb begin
        hazard_rs      = in_ID_use_rs && (in_ID_rs_idx != '0) && (cnt[in_ID_rs_idx] != '0);
        hazard_rt      = in_ID_use_rt && (in_ID_rt_idx != '0) && (cnt[in_ID_rt_idx] != '0);
        out_stall      = hazard_rs || hazard_rt;
        out_issue_fire = in_issue_valid && !out_stall && !in_hold && !in_flush;
        issue_rec      = out_issue_fire && in_issue_RegWr;
    end

    // Popcount of next-state counters so the registered count tracks cnt.
    always_comb begin
        busy_cnt_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(cnt_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign out_busy_cnt = 6'(busy_cnt_q);
    assign out_busy     = (busy_cnt_q != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] in_ID_rs_idx;
    logic [4:0] in_ID_rt_idx;
    logic       in_ID_use_rs;
    logic       in_ID_use_rt;
    logic       in_issue_valid;
    logic       in_issue_RegWr;
    logic [4:0] in_issue_rd_idx;
    logic [2:0] in_issue_lat;
    logic       in_hold;
    logic       in_flush;
    logic       out_stall;
    logic       out_issue_fire;
    logic [5:0] out_busy_cnt;
    logic       out_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_ID_rs_idx   (in_ID_rs_idx),
        .in_ID_rt_idx   (in_ID_rt_idx),
        .in_ID_use_rs   (in_ID_use_rs),
        .in_ID_use_rt   (in_ID_use_rt),
        .in_issue_valid (in_issue_valid),
        .in_issue_RegWr (in_issue_RegWr),
        .in_issue_rd_idx(in_issue_rd_idx),
        .in_issue_lat   (in_issue_lat),
        .in_hold        (in_hold),
        .in_flush       (in_flush),
        .out_stall      (out_stall),
        .out_issue_fire (out_issue_fire),
        .out_busy_cnt   (out_busy_cnt),
        .out_busy       (out_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_ID_rs_idx    = '0;
        in_ID_rt_idx    = '0;
        in_ID_use_rs    = 1'b0;
        in_ID_use_rt    = 1'b0;
        in_issue_valid  = 1'b0;
        in_issue_RegWr  = 1'b0;
        in_issue_rd_idx = '0;
        in_issue_lat    = '0;
        in_hold         = 1'b0;
        in_flush        = 1'b0;
    endtask

    // Issue a sourceless producer this cycle, then advance one edge.
    task automatic issue_prod(input logic [4:0] rd, input logic [2:0] lat);
        idle();
        in_issue_valid  = 1'b1;
        in_issue_RegWr  = 1'b1;
        in_issue_rd_idx = rd;
        in_issue_lat    = lat;
        #1;
        n_checks++;
        if (out_issue_fire !== 1'b1) begin
            n_fail++;
            $display("FAIL prod_fire rd=%0d got=%b exp=1", rd, out_issue_fire);
        end
        step();
    endtask

    task automatic flush_all();
        idle();
        in_flush = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n          = 1'b0;
        in_issue_valid = 1'b1;
        #12;
        n_checks++;
        if (out_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", out_stall); end
        n_checks++;
        if (out_issue_fire !== 1'b1) begin n_fail++; $display("FAIL reset_fire got=%b exp=1", out_issue_fire); end
        n_checks++;
        if (out_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
        n_checks++;
        if (out_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_busy_cnt got=%0d exp=0", out_busy_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step();
    endtask

    task automatic test_load_use();
        int stalls;
        issue_prod(5'd5, 3'd1);
        n_checks++;
        if (out_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL lu_busy_cnt1 got=%0d exp=1", out_busy_cnt); end
        in_ID_rs_idx = 5'd5; in_ID_rt_idx = 5'd7;
        in_ID_use_rs = 1'b1; in_ID_use_rt = 1'b1;
        in_issue_valid = 1'b1; in_issue_RegWr = 1'b1;
        in_issue_rd_idx = 5'd6; in_issue_lat = 3'd0;
        #1;
        stalls = 0;
        while (out_stall && stalls < 20) begin
            if (out_issue_fire !== 1'b0) begin n_fail++; $display("FAIL lu_fire_during_stall got=%b exp=0", out_issue_fire); end
            step();
            stalls++;
        end
        n_checks++;
        if (stalls != 1) begin n_fail++; $display("FAIL lu_stall_cycles got=%0d exp=1", stalls); end
        n_checks++;
        if (out_issue_fire !== 1'b1) begin n_fail++; $display("FAIL lu_add_fire got=%b exp=1", out_issue_fire); end
        n_checks++;
        if (out_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL lu_busy_cnt0 got=%0d exp=0", out_busy_cnt); end
        step();
        n_checks++;
        if (out_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL lu_alu_unrecorded got=%0d exp=0", out_busy_cnt); end
        idle();
    endtask

    // mult $8 (lat 4) then sub $9,$8,$8; hold during the 2nd and 3rd stall cycles if use_hold.
    task automatic test_mult(input bit use_hold, input int exp_stalls);
        int stalls;
        issue_prod(5'd8, 3'd4);
        in_ID_rs_idx = 5'd8; in_ID_rt_idx = 5'd8;
        in_ID_use_rs = 1'b1; in_ID_use_rt = 1'b1;
        in_issue_valid = 1'b1; in_issue_RegWr = 1'b1;
        in_issue_rd_idx = 5'd9; in_issue_lat = 3'd0;
        stalls = 0;
        #1;
        while (out_stall && stalls < 20) begin
            stalls++;
            in_hold = use_hold && (stalls == 2 || stalls == 3);
            step();
        end
        in_hold = 1'b0;
        #1;
        n_checks++;
        if (stalls != exp_stalls) begin n_fail++; $display("FAIL mult_stall_cycles hold=%0d got=%0d exp=%0d", use_hold, stalls, exp_stalls); end
        n_checks++;
        if (out_issue_fire !== 1'b1) begin n_fail++; $display("FAIL mult_sub_fire hold=%0d got=%b exp=1", use_hold, out_issue_fire); end
        step();
        idle();
    endtask

    task automatic test_waw();
        int stalls;
        issue_prod(5'd3, 3'd4);
        issue_prod(5'd3, 3'd1);
        n_checks++;
        if (out_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL waw_busy_cnt got=%0d exp=1", out_busy_cnt); end
        in_ID_rs_idx = 5'd3; in_ID_use_rs = 1'b1; in_issue_valid = 1'b1;
        #1;
        stalls = 0;
        while (out_stall && stalls < 20) begin
            step();
            stalls++;
        end
        n_checks++;
        if (stalls != 3) begin n_fail++; $display("FAIL waw_stall_cycles got=%0d exp=3", stalls); end
        idle();
        step();
    endtask

    task automatic test_flush();
        issue_prod(5'd10, 3'd5);
        issue_prod(5'd11, 3'd5);
        issue_prod(5'd12, 3'd5);
        n_checks++;
        if (out_busy_cnt !== 6'd3) begin n_fail++; $display("FAIL fl_busy_cnt3 got=%0d exp=3", out_busy_cnt); end
        in_ID_rs_idx = 5'd10; in_ID_use_rs = 1'b1;
        #1;
        n_checks++;
        if (out_stall !== 1'b1) begin n_fail++; $display("FAIL fl_pre_stall got=%b exp=1", out_stall); end
        // Flush together with an otherwise acceptable issue to $13.
        idle();
        in_flush = 1'b1;
        in_issue_valid = 1'b1; in_issue_RegWr = 1'b1;
        in_issue_rd_idx = 5'd13; in_issue_lat = 3'd5;
        #1;
        n_checks++;
        if (out_issue_fire !== 1'b0) begin n_fail++; $display("FAIL fl_fire_on_flush got=%b exp=0", out_issue_fire); end
        step();
        idle();
        n_checks++;
        if (out_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL fl_busy_cnt0 got=%0d exp=0", out_busy_cnt); end
        n_checks++;
        if (out_busy !== 1'b0) begin n_fail++; $display("FAIL fl_busy got=%b exp=0", out_busy); end
        in_ID_rs_idx = 5'd12; in_ID_rt_idx = 5'd13;
        in_ID_use_rs = 1'b1; in_ID_use_rt = 1'b1; in_issue_valid = 1'b1;
        #1;
        n_checks++;
        if (out_stall !== 1'b0) begin n_fail++; $display("FAIL fl_post_stall got=%b exp=0", out_stall); end
        n_checks++;
        if (out_issue_fire !== 1'b0 + 1'b1) begin n_fail++; $display("FAIL fl_post_fire got=%b exp=1", out_issue_fire); end
        idle();
        step();
    endtask

    task automatic test_reg0_and_itype();
        issue_prod(5'd0, 3'd5);
        n_checks++;
        if (out_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL r0_busy_cnt got=%0d exp=0", out_busy_cnt); end
        in_ID_rs_idx = 5'd0; in_ID_rt_idx = 5'd0;
        in_ID_use_rs = 1'b1; in_ID_use_rt = 1'b1;
        #1;
        n_checks++;
        if (out_stall !== 1'b0) begin n_fail++; $display("FAIL r0_src_stall got=%b exp=0", out_stall); end
        issue_prod(5'd14, 3'd5);
        in_ID_rs_idx = 5'd0; in_ID_rt_idx = 5'd14;
        in_ID_use_rs = 1'b1; in_ID_use_rt = 1'b0;
        #1;
        n_checks++;
        if (out_stall !== 1'b0) begin n_fail++; $display("FAIL itype_rt_stall got=%b exp=0", out_stall); end
        in_ID_use_rt = 1'b1;
        #1;
        n_checks++;
        if (out_stall !== 1'b1) begin n_fail++; $display("FAIL rtype_rt_stall got=%b exp=1", out_stall); end
        flush_all();
    endtask

    task automatic test_async_reset();
        issue_prod(5'd20, 3'd6);
        issue_prod(5'd21, 3'd6);
        n_checks++;
        if (out_busy_cnt !== 6'd2) begin n_fail++; $display("FAIL ar_busy_cnt2 got=%0d exp=2", out_busy_cnt); end
        #2;
        rst_n = 1'b0;
        in_ID_rs_idx = 5'd20; in_ID_use_rs = 1'b1;
        #1;
        n_checks++;
        if (out_busy_cnt !== 6'd0) begin n_fail++; $display("FAIL ar_busy_cnt0 got=%0d exp=0", out_busy_cnt); end
        n_checks++;
        if (out_stall !== 1'b0) begin n_fail++; $display("FAIL ar_stall got=%b exp=0", out_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        issue_prod(5'd22, 3'd1);
        n_checks++;
        if (out_busy_cnt !== 6'd1) begin n_fail++; $display("FAIL ar_post_busy_cnt got=%0d exp=1", out_busy_cnt); end
        flush_all();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mult(1'b0, 4);
        test_mult(1'b1, 6);
        test_waw();
        test_flush();
        test_reg0_and_itype();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

ID-stage register scoreboard that produces the values the EX-stage forwarding select consumes. Each instruction leaving ID records its destination register and the number of cycles until its result reaches a forwarding point. Each younger instruction's rs/rt is checked against this record, and out_stall is raised until every source operand is forwardable. This covers load-use hazards and multi-cycle producers such as mult/div and the AES unit. The block sits beside the ID/EX pipeline register and drives the PC/IF-ID hold and the ID/EX bubble insertion.

## Interface
- LAT_W, 3, width of the per-register latency counter; maximum producer latency is 2^LAT_W-1
- NREG, 32, number of architectural registers; register 0 is never tracked
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_ID_rs_idx  input  5  source register A of the instruction in ID
- in_ID_rt_idx  input  5  source register B of the instruction in ID
- in_ID_use_rs  input  1  instruction in ID actually reads rs
- in_ID_use_rt  input  1  instruction in ID reads rt as a source (low for I-type, where rt is the destination)
- in_issue_valid  input  1  instruction in ID requests to advance to EX
- in_issue_RegWr  input  1  advancing instruction writes a register
- in_issue_rd_idx  input  5  destination of the advancing instruction
- in_issue_lat  input  LAT_W  bubbles required before a consumer may issue: 0 for ALU, 1 for load, N for a multi-cycle unit
- in_hold  input  1  back end (EX/MEM) frozen; counters do not advance
- in_flush  input  1  squash everything younger than the resolving branch
- out_stall  output  1  instruction in ID must not advance
- out_issue_fire  output  1  issue accepted this cycle
- out_busy_cnt  output  6  number of registers with a nonzero counter
- out_busy  output  1  out_busy_cnt != 0

## Operation
- State: cnt[1..NREG-1], each LAT_W bits. Zero means forwardable or in the register file.
- Hazard on rs: in_ID_use_rs, rs_idx != 0, and cnt[rs] != 0. The rt hazard is defined the same way with in_ID_use_rt.
- out_stall = hazard_rs | hazard_rt. This output is combinational from the current state; the issue fields of the same cycle do not affect it.
- out_issue_fire = in_issue_valid & ~out_stall & ~in_hold & ~in_flush.
- Per-cycle update, in priority order:
  - in_flush: every cnt is cleared to 0.
  - in_hold: all cnt are held unchanged and no issue is recorded.
  - Otherwise every nonzero cnt decrements by 1. Then, if out_issue_fire & in_issue_RegWr & rd != 0, cnt[rd] loads max(in_issue_lat, cnt[rd]-1 saturated at 0). The max is taken against the value after this cycle's decrement; this keeps WAW ordering so a younger short op never unmarks an older long op.
- Issue with lat 0 leaves the register unmarked; the EX/MEM forward path covers it.
- Register 0 is never written and never hazards.
- out_busy_cnt is a registered population count, updated with the same rules. It equals popcount(cnt != 0) after every edge.

## Timing
- Reset: every cnt = 0, out_busy_cnt = 0. Combinationally out_stall = 0 and out_busy = 0; out_issue_fire follows in_issue_valid.
- Load at cycle T (lat 1): a dependent instruction in ID at T+1 sees out_stall = 1 and issues at T+2. This gives exactly one bubble, after which the MEM/WB forward path supplies the value.
- Producer with lat N at cycle T: its consumer stalls through cycle T+N and fires at T+N+1.
- Each in_hold cycle extends every pending stall by one cycle.
- Flush at T: no stall at T+1 regardless of prior state.
- Flush and issue in the same cycle: flush wins and nothing is recorded.
- rst_n asserted mid-operation clears state immediately and asynchronously. The first edge after deassertion behaves as post-reset.

## Structure
- Shared core package: LAT_W, NREG, the latency constants (LAT_ALU=0, LAT_LOAD=1, LAT_MULT, LAT_AES), and the reg-index type.
- One natural sub-module, sb_counter: a single LAT_W saturating down-counter with load-max and clear. It is instantiated NREG-1 times. The top level holds the index decode, stall logic and popcount.

## Test plan
- Reset with in_issue_valid=1 and no sources → out_stall=0, out_issue_fire=1, out_busy=0.
- lw $5 (lat 1) then add $6,$5,$7 → out_stall=1 for exactly 1 cycle, add fires on the 2nd cycle; out_busy_cnt 1→0.
- mult to $8 (lat 4), then sub $9,$8,$8 → 4 stall cycles; a 2-cycle in_hold in the middle extends this to 6.
- lat-4 op to $3, then a lat-1 op to $3 issued next cycle → cnt[3]=3 (not 1); a consumer of $3 stalls 3 cycles.
- in_flush while 3 registers are busy → out_busy_cnt=0 next cycle and a dependent issue fires immediately; flush+issue in the same cycle records nothing.
- Destination or source $0 with lat 5 → never stalls; I-type with in_ID_use_rt=0 and rt busy → no stall.
